// File: rtl/demux_1_to_2_buf_if.sv
// demux_1_to_2_buf_if
// Bundles the input handshake, both output handshakes and the statistics
// counters of the buffered 1-to-2 demultiplexer. The slave modport is the
// demux itself; the master modport is the producer/consumer side.

interface demux_1_to_2_buf_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             selector;
    logic [WIDTH-1:0] in;

    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0;

    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1;

    logic [15:0]      count0;
    logic [15:0]      count1;

    modport master (
        output in_valid, selector, in, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0, out1_valid, out1, count0, count1
    );

    modport slave (
        input  in_valid, selector, in, out0_ready, out1_ready,
        output in_ready, out0_valid, out0, out1_valid, out1, count0, count1
    );
endinterface

// File: rtl/demux_1_to_2_buf.sv
// demux_1_to_2_buf
// Buffered 1-to-2 demultiplexer. Each input word is steered by its selector
// bit into one of two independent DEPTH-entry circular FIFOs, each drained
// through its own valid/ready port. A full side only blocks words addressed
// to that side.
// Optional feature: define DEMUX_STATS_EN to enable the 16-bit per-side
// enqueue counters on count0/count1; otherwise both ports read 0.

module demux_1_to_2_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input logic               clk,
    input logic               rstb,
    demux_1_to_2_buf_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [1:0]       full;
    logic [1:0]       valid;
    logic [1:0]       out_rdy;
    logic [1:0]       enq;
    logic [1:0]       deq;
    logic             accept;
    logic             in_ready;
    logic [WIDTH-1:0] head [2];
    logic [15:0]      cnt  [2];

    // Readiness depends only on the registered occupancy of the addressed
    // side, so a consumer's ready can never ripple back to the producer.
    assign in_ready = bus.selector ? ~full[1] : ~full[0];
    assign accept   = bus.in_valid & in_ready;
    assign enq      = {accept & bus.selector, accept & ~bus.selector};
    assign out_rdy  = {bus.out1_ready, bus.out0_ready};
    assign deq      = valid & out_rdy;

    for (genvar s = 0; s < 2; s++) begin : g_side
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W-1:0] wr_ptr;
        logic [OCC_W-1:0] occ;

        assign full[s]  = (occ == OCC_FULL);
        assign valid[s] = (occ != '0);
        assign head[s]  = mem[rd_ptr];

        // FIFO storage, pointers and occupancy; enqueue and dequeue on the
        // same edge advance both pointers and leave occupancy unchanged.
        always_ff @(posedge clk) begin
            if (!rstb) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                occ    <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end else begin
                if (enq[s]) begin
                    mem[wr_ptr] <= bus.in;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (deq[s]) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({enq[s], deq[s]})
                    2'b10:   occ <= occ + OCC_W'(1);
                    2'b01:   occ <= occ - OCC_W'(1);
                    default: occ <= occ;
                endcase
            end
        end

`ifdef DEMUX_STATS_EN
        logic [15:0] stat;

        // Count accepted enqueues to this side; wraps naturally at 16 bits.
        always_ff @(posedge clk) begin
            if (!rstb) begin
                stat <= '0;
            end else if (enq[s]) begin
                stat <= stat + 16'd1;
            end
        end

        assign cnt[s] = stat;
`else
        assign cnt[s] = '0;
`endif
    end

    assign bus.in_ready   = in_ready;
    assign bus.out0_valid = valid[0];
    assign bus.out1_valid = valid[1];
    assign bus.out0       = head[0];
    assign bus.out1       = head[1];
    assign bus.count0     = cnt[0];
    assign bus.count1     = cnt[1];
endmodule

// File: doc/demux_1_to_2_buf.md
# demux_1_to_2_buf

Buffered 1-to-2 demultiplexer: accepts a WIDTH-bit word on a single valid/ready input port and routes it, by a per-word `selector` bit, into one of two independent output FIFOs, each drained through its own valid/ready port. It is the distribution counterpart of `mux_2_to_1`. It sits where one datapath result fans out to two consumers that may stall independently, for example a writeback bus feeding two pipeline sinks.

## Interface
- `WIDTH`, 32, data word width in bits.
- `DEPTH`, 2, entries per output FIFO; power of two, ≥2.
- `clk` input 1 — single clock, all state updates on rising edge.
- `rstb` input 1 — synchronous, active-low reset, sampled on `clk` rising edge.
- `in_valid` input 1 — input word present.
- `in_ready` output 1 — input can be accepted this cycle.
- `selector` input 1 — destination: 0 → out0, 1 → out1; qualified by `in_valid`.
- `in` input WIDTH — input data word.
- `out0_valid` / `out1_valid` output 1 — FIFO head valid.
- `out0_ready` / `out1_ready` input 1 — consumer accepts head.
- `out0` / `out1` output WIDTH — FIFO head data.
- `count0` / `count1` output 16 — transfer statistics (see Configuration).

## Operation
- Per side: DEPTH-entry circular FIFO, rd/wr pointers of log2(DEPTH) bits wrapping modulo DEPTH, occupancy counter 0..DEPTH.
- `in_ready` = NOT full(target side); target = `selector`; combinational from registered occupancy only, never from `outN_ready`.
- Enqueue: `in_valid && in_ready` at edge → word written at wr pointer of selected side, wr pointer +1, occupancy +1.
- Dequeue: `outN_valid && outN_ready` at edge → rd pointer +1, occupancy −1.
- Same-side enqueue+dequeue in one cycle: both pointers advance, occupancy unchanged; allowed at any occupancy < DEPTH (full blocks enqueue even if dequeuing).
- `outN_valid` = occupancy_N ≠ 0; `outN` = storage at rd pointer (registered storage, combinational read).
- Per-side order strictly FIFO; no ordering guarantee between sides.
- Full side never blocks the other: words for the non-full side accepted while the other is full.
- `outN_ready` while `outN_valid`=0: ignored, no state change.
- Reset (`rstb`=0 at edge): pointers, occupancies, storage, and counters all cleared to 0, regardless of in-flight handshakes; inputs that cycle are ignored.

## Timing
- Latency: word accepted at edge k → `outN_valid`=1 with that data after edge k (visible cycle k+1); earliest dequeue at edge k+1.
- Throughput: 1 word/cycle sustained per side when consumer holds ready=1 (occupancy oscillates ≤1).
- Reset values: `in_ready`=1, `out0_valid`=`out1_valid`=0, `out0`=`out1`=0, `count0`=`count1`=0.
- `in_ready` may change combinationally with `selector` in the same cycle; sources must hold `in`/`selector` stable while `in_valid`=1 and `in_ready`=0.

## Configuration
- `DEMUX_STATS_EN` defined: `countN` increments by 1 on each accepted enqueue to side N; 16-bit, wraps 0xFFFF→0x0000; cleared by reset.
- Not defined: counter logic absent, `count0`=`count1`=0 constantly; ports remain for stable instantiation.

## Test plan
- Reset: hold `rstb`=0 two cycles with `in_valid`=1 → all outputs at reset values, no enqueue; release → `in_ready`=1.
- Routing: push 0xAAAA0001 sel=0, 0xBBBB0002 sel=1, readies=1 → `out0`=0xAAAA0001 and `out1`=0xBBBB0002, each valid exactly one cycle, one cycle after acceptance.
- Full/backpressure: `out0_ready`=0, push 3 words sel=0 (DEPTH=2) → first two accepted, `in_ready`=0 on third; sel=1 word still accepted; raise `out0_ready` → 1, 2, then 3 drained in order.
- Simultaneous: occupancy 1, enqueue and dequeue same side same edge → occupancy stays 1, order preserved; pointer wrap verified over 10 words.
- Mid-operation reset: both FIFOs holding data, `rstb`=0 one edge → valids 0, data 0, counts 0; next pushes land at pointer 0.
- Stats (with `DEMUX_STATS_EN`): 65537 enqueues to side 1 → `count1`=1, `count0`=0; without macro both read 0.
